uart_rx_packer: RTL and testbench
=================================

Name: uart_rx_packer

Overview:
- UART receiver for the host-to-CAN direction: deserialises bytes arriving on the USB-UART RX pin and packs them into 32-bit words.
- Drives the 32-bit valid/ready transmit interface of can_top.
- Pairs with the existing uart_tx path (CAN RX -> UART TX) to close the UART<->CAN bridge.
- A partial word is flushed, zero-padded, after a configurable idle gap.

Parameters:
CLK_FREQ, 27000000, clock frequency in Hz
BAUD_RATE, 115200, UART bit rate
PARITY, "NONE", "NONE" / "ODD" / "EVEN"; when not NONE, one parity bit follows D7
FLUSH_BITS, 32, idle time in bit periods before a partial word is flushed; 0 disables flushing

Ports:
clk  input  1  single clock, all logic on rising edge
rstn  input  1  synchronous reset, active-low
i_uart_rx  input  1  asynchronous UART line, idle high
o_valid  output  1  o_data/o_nbytes hold a word
o_ready  input  1  downstream (can_top tx_ready) accepts the word
o_data  output  32  packed word; first received byte in [7:0]
o_nbytes  output  3  valid bytes in o_data, 1..4
o_parity_err  output  1  one-cycle pulse: parity mismatch, byte dropped
o_frame_err  output  1  one-cycle pulse: stop bit sampled 0, byte dropped
o_overflow  output  1  one-cycle pulse: completed word discarded because output was stalled

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rstn).
- Reset (rstn=0 at a clk edge):
  - All outputs 0; o_data=0; o_nbytes=0.
  - RX synchroniser preset to 1; FSM to IDLE; byte counter, packer and timers cleared.
  - A reset mid-frame or mid-word discards all partial data.
- Bit timing:
  - DIV = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, integer (234 at the defaults); HALF = DIV/2.
  - A 2-FF synchroniser feeds the FSM. All sampling uses the synchronised bit.
- FSM:
  - IDLE: a synchronised 1->0 transition starts a HALF-cycle count, then -> START.
  - START: sample at HALF. If 1, it is a false start -> IDLE, no error. If 0 -> DATA, bit counter = 0.
  - DATA: sample every DIV cycles, LSB first, 8 bits. Then -> PARITY if PARITY != NONE, else -> STOP.
  - PARITY: sample after DIV. EVEN requires the XOR of D0..D7 and the parity bit to be 0; ODD requires it to be 1. A mismatch flags the byte for a parity error. -> STOP.
  - STOP: sample after DIV.
    - Sample 0: o_frame_err pulses, byte dropped, -> BREAK.
    - Sample 1 with parity error: o_parity_err pulses, byte dropped, -> IDLE.
    - Otherwise: byte accepted, -> IDLE.
    - Both errors: only o_frame_err pulses.
  - BREAK: wait until the synchronised line is 1, then -> IDLE.
- Packing:
  - The k-th accepted byte (k=0..3) is written to bits [8k+7:8k] of the pack register; unused bytes are 0.
  - On the 4th byte the word is emitted with o_nbytes=4 and k returns to 0.
- Flush:
  - While k>0 and FSM in IDLE, an idle counter increments each cycle. It clears on every start-bit detect and every accepted byte.
  - When the counter reaches FLUSH_BITS*DIV, the partial word is emitted zero-padded with o_nbytes=k, and k returns to 0.
- Output handshake:
  - A word transfers on a cycle with o_valid=1 and o_ready=1.
  - o_data/o_nbytes are stable while o_valid=1 and o_ready=0.
  - Emit while o_valid=0: load the word, o_valid=1 on the next cycle.
  - Emit while o_valid=1 and o_ready=1 in the same cycle: load the new word, o_valid stays 1.
  - Emit while o_valid=1 and o_ready=0: the new word is discarded, o_overflow pulses, the held word is kept.
  - Transfer with no emit: o_valid=0 on the next cycle.
- Latency: the word appears 2 clk cycles after the STOP sample of its last byte: 1 cycle to emit, 1 cycle to register the output.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Constant function computing DIV from CLK_FREQ and BAUD_RATE, also used by uart_tx.
- One natural sub-module: uart_rx_byte (synchroniser, FSM, parity/frame checks; outputs a byte-valid strobe plus error strobes).
- Packing, flush timer and output register stay in uart_rx_packer.

Test Plan:
- Defaults, o_ready=1, send 0x11,0x22,0x33,0x44 back-to-back -> one word: o_data=0x44332211, o_nbytes=4, no error pulses.
- Send 0xA5 then idle for 32 bit periods (7488 cycles) -> o_data=0x000000A5, o_nbytes=1 within 7488+2 cycles; nothing is emitted before 7488 cycles.
- PARITY="EVEN": send 0x03 with parity bit 1 -> o_parity_err one pulse, no word. Then send 0x03 with parity bit 0 -> byte accepted.
- Hold the line low for 2 byte times -> single o_frame_err pulse. Then line high and send 0x55 -> accepted normally.
- o_ready=0: send 8 bytes 0x01..0x08 -> o_data holds 0x04030201 with o_valid=1, o_overflow one pulse, and the second word (0x08070605) is never emitted.
- Pulse the line low for 50 cycles (< HALF), then drive rstn=0 midway through a later byte -> no byte, no error, o_valid=0. The next full 4-byte word is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receive FSM state encoding and the
//               baud divider calculation used by both RX and TX paths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_rx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : UART byte receiver. 2-FF synchroniser, start/data/parity/stop
//               FSM and frame/parity checking. Emits one-cycle strobes.
// Ports       : clk, rstn          - clock, synchronous active-low reset
//               i_uart_rx          - asynchronous RX line, idle high
//               o_byte_valid/o_byte- accepted byte strobe and value
//               o_parity_err       - parity mismatch, byte dropped
//               o_frame_err        - stop bit sampled low, byte dropped
//               o_start            - start edge detected (pulse)
//               o_idle             - FSM is waiting for a start edge
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int    DIV    = 234,
    parameter string PARITY = "NONE"
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_uart_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_start,
    output logic       o_idle
);

    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(DIV - 1);
    localparam bit c_par_en  = (PARITY != "NONE");
    localparam bit c_par_odd = (PARITY == "ODD");

    logic             r_sync1, r_sync2, r_prev;
    uart_rx_state_t   r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_perr, w_perr_nxt;
    logic             r_byte_valid, w_byte_valid_nxt;
    logic             r_parity_err, w_parity_err_nxt;
    logic             r_frame_err, w_frame_err_nxt;
    logic             r_start, w_start_nxt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_byte_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_start      <= 1'b0;
        end else begin
            r_sync1      <= i_uart_rx;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_perr       <= w_perr_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_start      <= w_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + 1'b1;
        w_bit_nxt        = r_bit;
        w_shift_nxt      = r_shift;
        w_perr_nxt       = r_perr;
        w_byte_valid_nxt = 1'b0;
        w_parity_err_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_start_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (r_prev && !r_sync2) begin
                    w_state_nxt = ST_START;
                    w_start_nxt = 1'b1;
                end
            end
            ST_START: begin
                // Mid-bit check rejects glitches shorter than half a bit.
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt = '0;
                    if (r_sync2) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_bit_nxt   = '0;
                        w_perr_nxt  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (r_cnt == c_div_last) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (r_cnt == c_div_last) begin
                    w_cnt_nxt   = '0;
                    w_perr_nxt  = ((^r_shift) ^ r_sync2) != c_par_odd;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == c_div_last) begin
                    w_cnt_nxt = '0;
                    if (!r_sync2) begin
                        // Framing error wins over parity error.
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = ST_BREAK;
                    end else if (r_perr) begin
                        w_parity_err_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_byte_valid_nxt = 1'b1;
                        w_state_nxt      = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before a new start edge.
                w_cnt_nxt = '0;
                if (r_sync2) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_shift;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_start      = r_start;
    assign o_idle       = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_packer
// Description : Host-to-CAN UART receiver. Packs received bytes into 32-bit
//               words (first byte in [7:0]) and presents them on a
//               valid/ready interface. A partial word is flushed zero-padded
//               after FLUSH_BITS idle bit periods (0 disables flushing).
// Ports       : clk, rstn          - clock, synchronous active-low reset
//               i_uart_rx          - asynchronous RX line, idle high
//               o_valid/o_ready    - word handshake (o_ready is an input)
//               o_data/o_nbytes    - packed word and its byte count (1..4)
//               o_parity_err       - pulse: byte dropped on parity mismatch
//               o_frame_err        - pulse: byte dropped on bad stop bit
//               o_overflow         - pulse: word discarded, output stalled
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int    CLK_FREQ   = 27000000,
    parameter int    BAUD_RATE  = 115200,
    parameter string PARITY     = "NONE",
    parameter int    FLUSH_BITS = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_uart_rx,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_data,
    output logic [2:0]  o_nbytes,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_overflow
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_start;
    logic       w_idle;
    logic       w_flush;

    uart_rx_byte #(
        .DIV    (DIV),
        .PARITY (PARITY)
    ) u_rx_byte (
        .clk          (clk),
        .rstn         (rstn),
        .i_uart_rx    (i_uart_rx),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_start      (w_start),
        .o_idle       (w_idle)
    );

    // Packer: only three bytes are ever held; the fourth goes straight into
    // the emitted word.
    logic [1:0]  r_k;
    logic [23:0] r_pack;
    logic        r_emit;
    logic [31:0] r_emit_data;
    logic [2:0]  r_emit_nbytes;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_k           <= '0;
            r_pack        <= '0;
            r_emit        <= 1'b0;
            r_emit_data   <= '0;
            r_emit_nbytes <= '0;
        end else begin
            r_emit <= 1'b0;
            if (w_byte_valid) begin
                case (r_k)
                    2'd0: r_pack[7:0]   <= w_byte;
                    2'd1: r_pack[15:8]  <= w_byte;
                    2'd2: r_pack[23:16] <= w_byte;
                    default: begin
                        r_emit        <= 1'b1;
                        r_emit_data   <= {w_byte, r_pack};
                        r_emit_nbytes <= 3'd4;
                        r_pack        <= '0;
                    end
                endcase
                r_k <= r_k + 2'd1;
            end else if (w_flush) begin
                r_emit        <= 1'b1;
                r_emit_data   <= {8'h00, r_pack};
                r_emit_nbytes <= {1'b0, r_k};
                r_pack        <= '0;
                r_k           <= '0;
            end
        end
    end

    generate
        if (FLUSH_BITS > 0) begin : g_flush
            localparam logic [31:0] c_limit_last = 32'(FLUSH_BITS * DIV - 1);
            logic [31:0] r_idle_cnt;

            // Counts idle cycles only while a partial word is pending.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    r_idle_cnt <= '0;
                end else if (w_byte_valid || w_start || (r_k == 2'd0)) begin
                    r_idle_cnt <= '0;
                end else if (w_idle) begin
                    if (r_idle_cnt == c_limit_last) begin
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 32'd1;
                    end
                end
            end

            assign w_flush = (r_k != 2'd0) && w_idle && !w_start &&
                             (r_idle_cnt == c_limit_last);
        end else begin : g_no_flush
            assign w_flush = 1'b0;
        end
    endgenerate

    // Output register: a stalled holder keeps its word and the newcomer is
    // dropped with an overflow pulse.
    logic        r_valid;
    logic [31:0] r_data;
    logic [2:0]  r_nbytes;
    logic        r_overflow;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_nbytes   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (r_emit) begin
                if (!r_valid || o_ready) begin
                    r_valid  <= 1'b1;
                    r_data   <= r_emit_data;
                    r_nbytes <= r_emit_nbytes;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && o_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_nbytes   = r_nbytes;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_packer
// Description : Self-checking bench for uart_rx_packer. Instance u_dut uses
//               the defaults; u_dut_par uses EVEN parity and a short flush.
//               Expected words are queued at stimulus time and popped when
//               the DUT transfers a word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_packer;

    localparam int DIV    = 234;
    localparam int HALF   = DIV / 2;
    localparam int FLUSH0 = 32 * DIV;
    localparam int FLUSH1 = 4 * DIV;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx0, rx1, ready0, ready1;
    logic        valid0, valid1;
    logic [31:0] data0, data1;
    logic [2:0]  nbytes0, nbytes1;
    logic        perr0, ferr0, ovf0, perr1, ferr1, ovf1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int words0 = 0, words1 = 0, word_cyc0 = 0;
    int perr_cnt0 = 0, ferr_cnt0 = 0, ovf_cnt0 = 0;
    int perr_cnt1 = 0, ferr_cnt1 = 0, ovf_cnt1 = 0;
    int last_mid = 0;
    logic [34:0] q0[$];
    logic [34:0] q1[$];
    logic [34:0] exp0, exp1;

    uart_rx_packer u_dut (
        .clk(clk), .rstn(rstn), .i_uart_rx(rx0),
        .o_valid(valid0), .o_ready(ready0), .o_data(data0), .o_nbytes(nbytes0),
        .o_parity_err(perr0), .o_frame_err(ferr0), .o_overflow(ovf0)
    );

    uart_rx_packer #(.PARITY("EVEN"), .FLUSH_BITS(4)) u_dut_par (
        .clk(clk), .rstn(rstn), .i_uart_rx(rx1),
        .o_valid(valid1), .o_ready(ready1), .o_data(data1), .o_nbytes(nbytes1),
        .o_parity_err(perr1), .o_frame_err(ferr1), .o_overflow(ovf1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and pulse counters.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid0 && ready0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL word0_unexpected: got data=%h nbytes=%0d, expected no word", data0, nbytes0);
                end else begin
                    exp0 = q0.pop_front();
                    if ({data0, nbytes0} !== exp0) begin
                        errors++;
                        $display("FAIL word0_value: got data=%h nbytes=%0d, expected data=%h nbytes=%0d",
                                 data0, nbytes0, exp0[34:3], exp0[2:0]);
                    end
                end
                words0++;
                word_cyc0 = cyc;
            end
            if (valid1 && ready1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL word1_unexpected: got data=%h nbytes=%0d, expected no word", data1, nbytes1);
                end else begin
                    exp1 = q1.pop_front();
                    if ({data1, nbytes1} !== exp1) begin
                        errors++;
                        $display("FAIL word1_value: got data=%h nbytes=%0d, expected data=%h nbytes=%0d",
                                 data1, nbytes1, exp1[34:3], exp1[2:0]);
                    end
                end
                words1++;
            end
            if (perr0) perr_cnt0++;
            if (ferr0) ferr_cnt0++;
            if (ovf0)  ovf_cnt0++;
            if (perr1) perr_cnt1++;
            if (ferr1) ferr_cnt1++;
            if (ovf1)  ovf_cnt1++;
        end
    end

    // Entered and left on a falling clock edge.
    task automatic hold_line(input int sel, input logic v, input int cycles);
        if (sel == 0) rx0 = v; else rx1 = v;
        repeat (cycles) @(negedge clk);
    endtask

    // last_mid: clock edge at the middle of the stop bit on the line.
    task automatic send_byte(input int sel, input logic [7:0] d, input bit with_par, input bit par_bit);
        int n;
        n = cyc + 1;
        hold_line(sel, 1'b0, DIV);
        for (int i = 0; i < 8; i++) hold_line(sel, d[i], DIV);
        if (with_par) hold_line(sel, par_bit, DIV);
        hold_line(sel, 1'b1, DIV);
        last_mid = n + HALF + (with_par ? 10 : 9) * DIV;
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid0); end
        checks++;
        if (data0 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data0); end
        checks++;
        if (nbytes0 !== 3'd0) begin errors++; $display("FAIL reset_nbytes: got %0d expected 0", nbytes0); end
        checks++;
        if ({perr0, ferr0, ovf0} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {perr0, ferr0, ovf0});
        end
        checks++;
        if ({valid1, data1, nbytes1, perr1, ferr1, ovf1} !== 39'h0) begin
            errors++; $display("FAIL reset_par_outputs: got %h expected 0", {valid1, data1, nbytes1, perr1, ferr1, ovf1});
        end
        rstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_word();
        int w0;
        logic [7:0] bytes [4];
        w0 = words0;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        q0.push_back({32'h44332211, 3'd4});
        for (int i = 0; i < 4; i++) send_byte(0, bytes[i], 1'b0, 1'b0);
        for (int i = 0; i < 2 * DIV && words0 == w0; i++) @(negedge clk);
        checks++;
        if (words0 != w0 + 1) begin errors++; $display("FAIL word_count: got %0d expected %0d", words0 - w0, 1); end
        checks++;
        if (word_cyc0 < last_mid + 2 || word_cyc0 > last_mid + 6) begin
            errors++; $display("FAIL word_latency: got %0d cycles after mid-stop expected 2..6", word_cyc0 - last_mid);
        end
        checks++;
        if (perr_cnt0 + ferr_cnt0 + ovf_cnt0 != 0) begin
            errors++; $display("FAIL word_err_pulses: got %0d expected 0", perr_cnt0 + ferr_cnt0 + ovf_cnt0);
        end
    endtask

    task automatic test_flush();
        int w0;
        w0 = words0;
        q0.push_back({32'h000000A5, 3'd1});
        send_byte(0, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < FLUSH0 + DIV && words0 == w0; i++) @(negedge clk);
        checks++;
        if (words0 != w0 + 1) begin errors++; $display("FAIL flush_count: got %0d expected %0d", words0 - w0, 1); end
        checks++;
        if (word_cyc0 < last_mid + FLUSH0 || word_cyc0 > last_mid + FLUSH0 + 6) begin
            errors++; $display("FAIL flush_time: got %0d cycles after mid-stop expected %0d..%0d",
                               word_cyc0 - last_mid, FLUSH0, FLUSH0 + 6);
        end
    endtask

    task automatic test_parity();
        int w1, pe1, fe1;
        w1 = words1; pe1 = perr_cnt1; fe1 = ferr_cnt1;
        send_byte(1, 8'h03, 1'b1, 1'b1);
        hold_line(1, 1'b1, 2 * DIV + FLUSH1);
        checks++;
        if (perr_cnt1 != pe1 + 1) begin errors++; $display("FAIL parity_pulse: got %0d expected 1", perr_cnt1 - pe1); end
        checks++;
        if (words1 != w1 || ferr_cnt1 != fe1) begin
            errors++; $display("FAIL parity_dropped: got words=%0d frame=%0d expected 0 0", words1 - w1, ferr_cnt1 - fe1);
        end
        q1.push_back({32'h00000003, 3'd1});
        send_byte(1, 8'h03, 1'b1, 1'b0);
        for (int i = 0; i < FLUSH1 + 2 * DIV && words1 == w1; i++) @(negedge clk);
        checks++;
        if (words1 != w1 + 1) begin errors++; $display("FAIL parity_good_count: got %0d expected 1", words1 - w1); end
        checks++;
        if (perr_cnt1 != pe1 + 1) begin errors++; $display("FAIL parity_good_pulse: got %0d expected 1", perr_cnt1 - pe1); end
    endtask

    task automatic test_frame();
        int w0, fe0, pe0;
        w0 = words0; fe0 = ferr_cnt0; pe0 = perr_cnt0;
        hold_line(0, 1'b0, 20 * DIV);
        hold_line(0, 1'b1, 2 * DIV);
        checks++;
        if (ferr_cnt0 != fe0 + 1) begin errors++; $display("FAIL frame_pulse: got %0d expected 1", ferr_cnt0 - fe0); end
        checks++;
        if (perr_cnt0 != pe0 || words0 != w0) begin
            errors++; $display("FAIL frame_side: got parity=%0d words=%0d expected 0 0", perr_cnt0 - pe0, words0 - w0);
        end
        q0.push_back({32'h00000055, 3'd1});
        send_byte(0, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < FLUSH0 + DIV && words0 == w0; i++) @(negedge clk);
        checks++;
        if (words0 != w0 + 1) begin errors++; $display("FAIL frame_recover: got %0d expected 1", words0 - w0); end
    endtask

    task automatic test_overflow();
        int w0, ov0;
        w0 = words0; ov0 = ovf_cnt0;
        ready0 = 1'b0;
        q0.push_back({32'h04030201, 3'd4});
        for (int i = 1; i <= 8; i++) send_byte(0, 8'(i), 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (valid0 !== 1'b1 || data0 !== 32'h04030201 || nbytes0 !== 3'd4) begin
            errors++; $display("FAIL ovf_hold: got valid=%b data=%h nbytes=%0d expected 1 04030201 4", valid0, data0, nbytes0);
        end
        checks++;
        if (ovf_cnt0 != ov0 + 1) begin errors++; $display("FAIL ovf_pulse: got %0d expected 1", ovf_cnt0 - ov0); end
        @(posedge clk);
        #1 ready0 = 1'b1;
        @(negedge clk);
        repeat (DIV) @(negedge clk);
        checks++;
        if (words0 != w0 + 1) begin errors++; $display("FAIL ovf_words: got %0d expected 1", words0 - w0); end
    endtask

    task automatic test_reset_midframe();
        int w0, fe0, pe0;
        logic [7:0] bytes [4];
        w0 = words0; fe0 = ferr_cnt0; pe0 = perr_cnt0;
        hold_line(0, 1'b0, 50);
        hold_line(0, 1'b1, 2 * DIV);
        send_byte(0, 8'hAA, 1'b0, 1'b0);
        send_byte(0, 8'hBB, 1'b0, 1'b0);
        hold_line(0, 1'b0, DIV);
        hold_line(0, 1'b0, DIV);
        hold_line(0, 1'b0, DIV);
        hold_line(0, 1'b1, DIV / 2);
        rstn = 1'b0;
        hold_line(0, 1'b1, 5);
        rstn = 1'b1;
        hold_line(0, 1'b1, 2 * DIV);
        checks++;
        if (valid0 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", valid0); end
        checks++;
        if (words0 != w0 || ferr_cnt0 != fe0 || perr_cnt0 != pe0) begin
            errors++; $display("FAIL rstmid_quiet: got words=%0d frame=%0d parity=%0d expected 0 0 0",
                               words0 - w0, ferr_cnt0 - fe0, perr_cnt0 - pe0);
        end
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        q0.push_back({32'hEFBEADDE, 3'd4});
        for (int i = 0; i < 4; i++) send_byte(0, bytes[i], 1'b0, 1'b0);
        for (int i = 0; i < 2 * DIV && words0 == w0; i++) @(negedge clk);
        checks++;
        if (words0 != w0 + 1) begin errors++; $display("FAIL rstmid_next_word: got %0d expected 1", words0 - w0); end
    endtask

    task automatic test_drain();
        repeat (DIV) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL drain: got %0d/%0d words outstanding expected 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_flush();
        test_parity();
        test_frame();
        test_overflow();
        test_reset_midframe();
        test_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
